// File: rtl/button_conditioner.sv
// Push-button front end: synchroniser, two-edge debounce, press/release/long-press strobes
// and a clean held level. All outputs are registered; reset is synchronous, active-high.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// IDLE          | button released and stable, waiting for an active sample
// PRESS_CHECK   | counting consecutive active samples before accepting press
// PRESSED       | press accepted, hold timer running toward long press
// RELEASE_CHECK | counting consecutive inactive samples before accepting release
module button_conditioner #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 4,
   parameter int LONG_PRESS_CYCLES = 20,
   parameter bit ACTIVE_LOW        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic button_raw,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse,
   output logic pressed
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DEB_W-1:0]  DEB_ONE  = DEB_W'(1);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      PRESS_CHECK   = 2'd1,
      PRESSED       = 2'd2,
      RELEASE_CHECK = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [DEB_W-1:0]    deb_cnt, deb_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic                press_nxt, release_nxt, long_nxt, pressed_nxt;

   logic                raw_active;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                sample;

   // Inversion sits in front of the chain so the flops reset to the inactive level.
   assign raw_active = ACTIVE_LOW ? ~button_raw : button_raw;
   assign sample     = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_active};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         deb_cnt          <= '0;
         hold_cnt         <= '0;
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;
         pressed          <= 1'b0;
      end else begin
         state            <= state_nxt;
         deb_cnt          <= deb_nxt;
         hold_cnt         <= hold_nxt;
         press_pulse      <= press_nxt;
         release_pulse    <= release_nxt;
         long_press_pulse <= long_nxt;
         pressed          <= pressed_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      deb_nxt     = deb_cnt;
      hold_nxt    = hold_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;

      // Hold timer runs through release bounces so a long press is not lost to chatter.
      if (state == PRESSED || state == RELEASE_CHECK) begin
         if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
         end
         long_nxt = (hold_cnt == HOLD_PRE);
      end

      case (state)
         IDLE: begin
            if (sample) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt = PRESSED;
                  press_nxt = 1'b1;
                  hold_nxt  = '0;
                  deb_nxt   = '0;
               end else begin
                  state_nxt = PRESS_CHECK;
                  deb_nxt   = DEB_ONE;
               end
            end
         end
         PRESS_CHECK: begin
            if (!sample) begin
               state_nxt = IDLE;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = PRESSED;
               press_nxt = 1'b1;
               hold_nxt  = '0;
               deb_nxt   = '0;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!sample) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_nxt   = IDLE;
                  release_nxt = 1'b1;
                  hold_nxt    = '0;
                  deb_nxt     = '0;
               end else begin
                  state_nxt = RELEASE_CHECK;
                  deb_nxt   = DEB_ONE;
               end
            end
         end
         RELEASE_CHECK: begin
            if (sample) begin
               state_nxt = PRESSED;
               deb_nxt   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               hold_nxt    = '0;
               deb_nxt     = '0;
            end else begin
               deb_nxt = deb_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            deb_nxt   = '0;
            hold_nxt  = '0;
         end
      endcase

      pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHECK);
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a default instance and an active-low, single-sample
// debounce instance, checked every cycle against a run-length reference model.
module tb_button_conditioner;

   localparam int SYNC = 2;
   localparam int DEB0 = 4;
   localparam int DEB1 = 1;
   localparam int LONG = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw0 = 1'b0;
   logic raw1 = 1'b1;
   logic p0, r0, l0, h0;
   logic p1, r1, l1, h1;

   always #5 clk = ~clk;

   button_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB0), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b0)
   ) dut0 (
      .clk(clk), .rst(rst), .button_raw(raw0),
      .press_pulse(p0), .release_pulse(r0), .long_press_pulse(l0), .pressed(h0)
   );

   button_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB1), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst), .button_raw(raw1),
      .press_pulse(p1), .release_pulse(r1), .long_press_pulse(l1), .pressed(h1)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: sample is the active raw value SYNC edges ago; the level flips once
   // the number of consecutive samples disagreeing with it reaches the debounce count.
   bit pipe [2][SYNC];
   bit lvl  [2];
   int run  [2];
   int held [2];
   bit e_p  [2];
   bit e_r  [2];
   bit e_l  [2];

   int n_press0, n_rel0, n_long0, t_press0, t_rel0, t_long0;
   int n_press1, n_rel1, t_press1, t_rel1;

   task automatic model_step(input int i, input bit raw, input bit r);
      int deb;
      bit s;
      deb = (i == 0) ? DEB0 : DEB1;
      e_p[i] = 1'b0;
      e_r[i] = 1'b0;
      e_l[i] = 1'b0;
      if (r) begin
         for (int k = 0; k < SYNC; k++) pipe[i][k] = 1'b0;
         lvl[i]  = 1'b0;
         run[i]  = 0;
         held[i] = 0;
      end else begin
         s = pipe[i][SYNC-1];
         for (int k = SYNC - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
         pipe[i][0] = raw ^ (i == 1);
         if (lvl[i] && held[i] < LONG) begin
            held[i]++;
            if (held[i] == LONG) e_l[i] = 1'b1;
         end
         if (s != lvl[i]) begin
            run[i]++;
            if (run[i] == deb) begin
               run[i]  = 0;
               held[i] = 0;
               if (lvl[i]) e_r[i] = 1'b1;
               else        e_p[i] = 1'b1;
               lvl[i] = ~lvl[i];
            end
         end else begin
            run[i] = 0;
         end
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic a, input logic b, input logic r);
      raw0 = a;
      raw1 = b;
      rst  = r;
      @(posedge clk);
      model_step(0, a, r);
      model_step(1, b, r);
      #1;
      cyc++;
      check("press0", p0, e_p[0]);
      check("release0", r0, e_r[0]);
      check("long0", l0, e_l[0]);
      check("pressed0", h0, lvl[0]);
      check("press1", p1, e_p[1]);
      check("release1", r1, e_r[1]);
      check("long1", l1, e_l[1]);
      check("pressed1", h1, lvl[1]);
      if (p0) begin n_press0++; t_press0 = cyc; end
      if (r0) begin n_rel0++;   t_rel0   = cyc; end
      if (l0) begin n_long0++;  t_long0  = cyc; end
      if (p1) begin n_press1++; t_press1 = cyc; end
      if (r1) begin n_rel1++;   t_rel1   = cyc; end
   endtask

   task automatic clr();
      n_press0 = 0; n_rel0 = 0; n_long0 = 0; t_press0 = -1; t_rel0 = -1; t_long0 = -1;
      n_press1 = 0; n_rel1 = 0; t_press1 = -1; t_rel1 = -1;
   endtask

   task automatic reset_all();
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      clr();
   endtask

   initial begin
      int mark;
      bit  v0, v1;
      int  len0, len1;
      clr();

      // Reset then clean press on the default instance
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, 1'b1);
         check("rst_outs0", p0 | r0 | l0 | h0, 1'b0);
      end
      clr();
      mark = cyc;
      for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b0);
      check_int("press_latency", t_press0 - mark, 6);
      check_int("press_count", n_press0, 1);
      check_int("no_early_long", n_long0, 0);
      check("held_after_press", h0, 1'b1);

      // Press bounce: 1,1,1,0 then a steady run
      reset_all();
      mark = cyc;
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) tick(1'b1, 1'b1, 1'b0);
      check_int("bounce_press_edge", t_press0 - mark, 10);
      check_int("bounce_press_count", n_press0, 1);

      // Long press, then release
      reset_all();
      mark = cyc;
      for (int k = 0; k < 40; k++) tick(1'b1, 1'b1, 1'b0);
      check_int("long_press_latency", t_press0 - mark, 6);
      check_int("long_count", n_long0, 1);
      check_int("long_after_press", t_long0 - t_press0, 20);
      mark = cyc;
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b0);
      check_int("release_latency", t_rel0 - mark, 6);
      check_int("release_count", n_rel0, 1);
      check("released_level", h0, 1'b0);

      // Release bounce keeps the hold timer running
      reset_all();
      mark = cyc;
      for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 25; k++) tick(1'b1, 1'b1, 1'b0);
      check_int("rb_no_release", n_rel0, 0);
      check("rb_still_held", h0, 1'b1);
      check_int("rb_long_count", n_long0, 1);
      check_int("rb_long_timing", t_long0 - t_press0, 20);

      // Reset in the middle of a press
      reset_all();
      for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      check("midrst_pressed", h0, 1'b0);
      check("midrst_strobes", p0 | r0 | l0, 1'b0);
      mark = cyc;
      for (int k = 0; k < 12; k++) tick(1'b1, 1'b1, 1'b0);
      check_int("midrst_repress", t_press0 - mark, 6);
      check_int("midrst_press_count", n_press0, 2);
      check_int("midrst_no_release", n_rel0, 0);

      // Active-low, single-sample debounce instance
      reset_all();
      mark = cyc;
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0);
      check_int("al_press_latency", t_press1 - mark, 3);
      check("al_held", h1, 1'b1);
      mark = cyc;
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, 1'b0);
      check_int("al_release_latency", t_rel1 - mark, 3);
      check_int("al_counts", n_press1 + n_rel1, 2);

      // Random runs of bouncy and steady input, occasional reset
      len0 = 0;
      len1 = 0;
      v0 = 1'b0;
      v1 = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (len0 == 0) begin
            v0   = $urandom_range(0, 1);
            len0 = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 6);
         end
         if (len1 == 0) begin
            v1   = $urandom_range(0, 1);
            len1 = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 40) : $urandom_range(1, 4);
         end
         tick(v0, v1, ($urandom_range(0, 299) == 0));
         len0--;
         len1--;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
